// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared FSM state encoding and frame constants for uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // One start bit, eight data bits, one stop bit.
    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = UART_FRAME_BITS - 2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Producer-side byte handshake (enable/data/busy) into uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;

    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_en,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx_busy
    );

endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : First-word-fall-through byte FIFO, pointer-wrap full/empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      push,
    input  wire                      pop,
    input  wire  [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    // A push at full is legal only when the head leaves in the same cycle.
    assign w_rd = pop && !empty;
    assign w_wr = push && (!full || w_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign count = r_wr_ptr - r_rd_ptr;
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                   (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Buffered 8N1 UART transmitter with early-busy byte FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire        clk,
    input  wire        rst,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       overflow
);

    localparam int                   c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam int                   c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_baud_w-1:0]  c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [2:0]           c_last_bit  = 3'(UART_DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0]   c_depth     = c_cnt_w'(FIFO_DEPTH);

    uart_state_t         r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;

    logic                w_baud_done;
    logic                w_pop;
    logic                w_push;
    logic                w_empty;
    logic                w_full;
    logic [7:0]          w_head;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w-1:0]  w_free;

    assign w_baud_done = (r_baud == c_baud_last);
    assign w_pop       = !w_empty &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));
    assign w_push      = bus.tx_en && (!w_full || w_pop);

    // Busy one entry early so a producer reacting a cycle late still fits.
    assign w_free      = c_depth - w_count;
    assign bus.tx_busy = (w_free <= c_cnt_w'(1));

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.tx_data),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (bus.tx_en && !w_push) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            tx        <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        tx      <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        tx        <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_last_bit) begin
                            tx      <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            // Next bit is shift[1], which becomes shift[0] after this shift.
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                            tx        <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            tx      <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    tx      <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter that sits between the puzzle core's byte output (enable/data/busy handshake) and the board's serial TX pin. Bytes are accepted one per cycle into a small FIFO, then serialized LSB-first at a fixed baud rate derived from a clock-divider parameter. Busy asserts early enough that the puzzle core's one-cycle-late write never overflows the buffer.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit (12 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, default 16: byte buffer entries. Power of two, ≥ 4.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  write strobe; `tx_data` is captured on any rising edge where `tx_en` is high.
- `tx_data`  in  8  byte to send.
- `tx_busy`  out  1  high when free FIFO entries ≤ 1; producer must not start a new write.
- `tx`  out  1  serial line, idle high; registered.
- `overflow`  out  1  sticky; set when a write is dropped.

## Operation
- FIFO write: on `tx_en`, push `tx_data` if count < FIFO_DEPTH or a pop occurs in the same cycle. Otherwise drop the byte and set `overflow`.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal at full and at empty+1.
- `tx_busy` = (FIFO_DEPTH − count) ≤ 1. It is combinational from the registered count. The one-entry margin covers a producer that samples busy and writes on the following cycle.
- FSM states and transitions:
  - IDLE: `tx` = 1. If FIFO is non-empty: pop the head into the shift register, drive the start bit, go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop and go directly to START, with no extra idle cycle. Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT−1 and clears on every state or bit change. Width is $clog2(CLKS_PER_BIT).
- Bit index: 3 bits, 0..7.
- Reset values: `tx` = 1, `tx_busy` = 0, `overflow` = 0, FIFO empty, FSM IDLE. Reset takes effect immediately and asynchronously, including mid-frame; a partial frame is abandoned.
- `overflow` clears only on reset.

## Timing
- Latency: for a write at edge t into an empty FIFO with FSM IDLE, the FIFO is non-empty after t. The FSM pops at edge t+1, and `tx` falls (start bit) after edge t+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles, from start-bit falling edge to the end of the stop bit.
- Back-to-back bytes: the next start bit immediately follows the stop bit's last cycle. Throughput is one byte per 10·CLKS_PER_BIT cycles.
- Write throughput: one byte per cycle until `tx_busy` asserts.
- Wrap-around: FIFO pointers are $clog2(FIFO_DEPTH)+1 bits with an MSB wrap flag. Full/empty are derived from the pointers and count with no lost entry.

## Structure
- Package `uart_pkg`: FSM state encoding (IDLE, START, DATA, STOP) and the `UART_FRAME_BITS = 10` constant.
- Sub-module `byte_fifo`:
  - Parameter: `DEPTH`.
  - Ports: push/pop/din/dout/count/empty/full.
  - Read is first-word-fall-through.
  - Reset is asynchronous, active-high.
- `uart_tx` holds the FSM, baud counter, shift register, busy/overflow logic, and the `tx` register.

## Test plan
All scenarios run with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4.
- Single byte: write 0x41 to an idle block.
  - `tx` falls 2 edges after the write.
  - Sampled bit-centres read 0,1,0,0,0,0,0,1,0,1 (start, LSB-first, stop).
  - `tx` then stays high.
- Burst: write 0x55, 0xAA, 0x0F on consecutive cycles.
  - Three contiguous 40-cycle frames with no idle gap.
  - Decoded bytes are 0x55, 0xAA, 0x0F, in order.
- Busy margin: write every cycle while `tx_busy` = 0, with the producer seeing busy one cycle late.
  - `tx_busy` rises when count reaches 3.
  - The late write fills entry 4.
  - `overflow` stays 0.
- Overflow: with the FIFO full and the FSM mid-DATA, force a write of 0x99.
  - `overflow` = 1.
  - 0x99 is never transmitted.
  - Queued bytes are unchanged.
- Push/pop same cycle at full: schedule a write on the exact cycle STOP pops the next byte.
  - Count stays 4, no overflow, and all bytes are sent in order.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x3C.
  - `tx` = 1 within the same cycle; FIFO is empty; `tx_busy` = 0.
  - After release, writing 0x12 yields one clean frame.
